// File: rtl/sys_rst_pkg.sv
// ---------------------------------------------------------------------------
// sys_rst_pkg
// Shared types and default timing for the refclk-domain reset sequencer.
// Defaults are for a 24 MHz reference clock.
// ---------------------------------------------------------------------------
package sys_rst_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  localparam int RELOCK_W = 8;

  localparam int DEF_NUM_RST             = 3;
  localparam int DEF_PLL_RST_CYCLES      = 24;     // 1 us
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 24000;  // 1 ms
  localparam int DEF_LOCK_STABLE_CYCLES  = 240;    // 10 us
  localparam int DEF_STAGGER_CYCLES      = 16;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sys_rst_ctrl_sync2.sv
// ---------------------------------------------------------------------------
// sys_sync2
// Two-flop single-bit synchronizer with asynchronous active-low clear.
// Ports:
//   i_clk   - destination clock
//   i_rst_n - async active-low clear (output forced low)
//   i_d     - asynchronous input bit
//   o_q     - synchronized output, two clock edges behind i_d
// ---------------------------------------------------------------------------
module sys_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sys_rst_ctrl.sv
// ---------------------------------------------------------------------------
// sys_rst_ctrl
// Reset sequencer behind the system PLL wrapper. Pulses the PLL reset,
// qualifies lock, then releases the system resets in index order with a
// fixed stagger. Lock loss (RELEASE/RUN) restarts from the PLL reset and is
// counted; a software request in RUN restarts from lock qualification.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// PLL_RST    | o_pll_rst high for PLL_RST_CYCLES
// WAIT_LOCK  | waiting for synchronized lock, bounded by LOCK_TIMEOUT_CYCLES
// STABLE     | lock must stay high for LOCK_STABLE_CYCLES
// RELEASE    | o_sys_rst_n bits rise every STAGGER_CYCLES, bit 0 on entry
// RUN        | all resets released, o_rst_done high
//
// Ports:
//   i_refclk        - free-running reference clock (only clock)
//   i_rst_n         - async active-low board reset
//   i_pll_locked    - PLL lock, asynchronous to i_refclk
//   i_sw_reset_req  - single-cycle software reset request (used in RUN only)
//   o_pll_rst       - active-high PLL reset
//   o_sys_rst_n     - active-low sequenced system resets
//   o_rst_done      - high only in RUN
//   o_relock_count  - saturating count of lock losses after release
// ---------------------------------------------------------------------------
module sys_rst_ctrl
  import sys_rst_pkg::*;
#(
  parameter int NUM_RST             = DEF_NUM_RST,
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int STAGGER_CYCLES      = DEF_STAGGER_CYCLES
) (
  input  logic                i_refclk,
  input  logic                i_rst_n,
  input  logic                i_pll_locked,
  input  logic                i_sw_reset_req,
  output logic                o_pll_rst,
  output logic [NUM_RST-1:0]  o_sys_rst_n,
  output logic                o_rst_done,
  output logic [RELOCK_W-1:0] o_relock_count
);

  localparam int CNT_MAX  = max_of4(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                    LOCK_STABLE_CYCLES, NUM_RST * STAGGER_CYCLES);
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int LAST_TAP = (NUM_RST - 1) * STAGGER_CYCLES;

  logic                w_rst_ok;
  logic                w_lock_s;
  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_lock_loss;
  logic                w_tap;
  logic [NUM_RST-1:0]  w_rel_nxt;
  logic                r_pll_rst;
  logic [NUM_RST-1:0]  r_sys_rst_n;
  logic                r_rst_done;
  logic [RELOCK_W-1:0] r_relock_cnt;

  // Board reset asserts asynchronously everywhere; its release only lets the
  // FSM advance once it has passed through the synchronizer.
  sys_sync2 u_rst_sync (
    .i_clk   (i_refclk),
    .i_rst_n (i_rst_n),
    .i_d     (1'b1),
    .o_q     (w_rst_ok)
  );

  sys_sync2 u_lock_sync (
    .i_clk   (i_refclk),
    .i_rst_n (i_rst_n),
    .i_d     (i_pll_locked),
    .o_q     (w_lock_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_lock_loss = 1'b0;
    if (w_rst_ok) begin
      unique case (r_state)
        ST_PLL_RST:
          if (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) w_state_nxt = ST_WAIT_LOCK;
        ST_WAIT_LOCK:
          if (w_lock_s)                                    w_state_nxt = ST_STABLE;
          else if (r_cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) w_state_nxt = ST_PLL_RST;
        ST_STABLE:
          if (!w_lock_s)                                   w_state_nxt = ST_WAIT_LOCK;
          else if (r_cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) w_state_nxt = ST_RELEASE;
        ST_RELEASE:
          if (!w_lock_s) begin
            w_state_nxt = ST_PLL_RST;
            w_lock_loss = 1'b1;
          end else if (r_cnt == CNT_W'(LAST_TAP)) begin
            w_state_nxt = ST_RUN;
          end
        ST_RUN:
          // lock loss takes priority over a coincident software request
          if (!w_lock_s) begin
            w_state_nxt = ST_PLL_RST;
            w_lock_loss = 1'b1;
          end else if (i_sw_reset_req) begin
            w_state_nxt = ST_STABLE;
          end
        default: w_state_nxt = ST_PLL_RST;
      endcase
    end
  end

  // Shared counter: cleared on every state change, parked in RUN.
  always_comb begin
    if (!w_rst_ok)
      w_cnt_nxt = r_cnt;
    else if (w_state_nxt != r_state || r_state == ST_RUN)
      w_cnt_nxt = '0;
    else
      w_cnt_nxt = r_cnt + 1'b1;
  end

  // A tap fires on the edge where the counter reaches i*STAGGER_CYCLES.
  always_comb begin
    w_tap = 1'b0;
    for (int i = 1; i < NUM_RST; i++) begin
      if (r_cnt == CNT_W'(i * STAGGER_CYCLES - 1)) w_tap = 1'b1;
    end
  end

  // Shifting ones in from bit 0 keeps releases strictly in index order.
  always_comb begin
    w_rel_nxt = '0;
    if (w_state_nxt == ST_RELEASE && r_state != ST_RELEASE)
      w_rel_nxt[0] = 1'b1;
    else if (w_state_nxt == ST_RELEASE && w_tap)
      w_rel_nxt = (r_sys_rst_n << 1) | NUM_RST'(1);
    else if (w_state_nxt == ST_RELEASE || w_state_nxt == ST_RUN)
      w_rel_nxt = r_sys_rst_n;
  end

  always_ff @(posedge i_refclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_PLL_RST;
      r_cnt        <= '0;
      r_pll_rst    <= 1'b1;
      r_sys_rst_n  <= '0;
      r_rst_done   <= 1'b0;
      r_relock_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pll_rst   <= (w_state_nxt == ST_PLL_RST);
      r_sys_rst_n <= w_rel_nxt;
      r_rst_done  <= (w_state_nxt == ST_RUN);
      if (w_lock_loss && r_relock_cnt != '1)
        r_relock_cnt <= r_relock_cnt + 1'b1;
    end
  end

  assign o_pll_rst      = r_pll_rst;
  assign o_sys_rst_n    = r_sys_rst_n;
  assign o_rst_done     = r_rst_done;
  assign o_relock_count = r_relock_cnt;

endmodule

// File: tb/tb_sys_rst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sys_rst_ctrl
// Scoreboard bench for sys_rst_ctrl. The driver advances a phase/timestamp
// reference model once per clock and queues the expected outputs; the
// monitor pops one entry per cycle (and once right after an asynchronous
// reset assertion) and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_sys_rst_ctrl;

  localparam int N_RST  = 3;
  localparam int PLL_C  = 4;
  localparam int TO_C   = 50;
  localparam int STB_C  = 8;
  localparam int STG_C  = 3;

  logic             clk;
  logic             rst_n;
  logic             pll_locked;
  logic             sw_reset_req;
  logic             pll_rst;
  logic [N_RST-1:0] sys_rst_n;
  logic             rst_done;
  logic [7:0]       relock_count;

  sys_rst_ctrl #(
    .NUM_RST             (N_RST),
    .PLL_RST_CYCLES      (PLL_C),
    .LOCK_TIMEOUT_CYCLES (TO_C),
    .LOCK_STABLE_CYCLES  (STB_C),
    .STAGGER_CYCLES      (STG_C)
  ) dut (
    .i_refclk       (clk),
    .i_rst_n        (rst_n),
    .i_pll_locked   (pll_locked),
    .i_sw_reset_req (sw_reset_req),
    .o_pll_rst      (pll_rst),
    .o_sys_rst_n    (sys_rst_n),
    .o_rst_done     (rst_done),
    .o_relock_count (relock_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             pll;
    logic [N_RST-1:0] sys;
    logic             done;
    logic [7:0]       rc;
  } exp_t;

  typedef enum int {P_PLL, P_WAIT, P_STAB, P_REL, P_RUN} phase_t;

  exp_t   sb_q[$];
  event   ev_async;
  int     n_checks = 0;
  int     n_fail   = 0;

  // reference model: current phase, edge of entry, edges since reset release
  phase_t m_ph;
  int     m_now;
  int     m_tin;
  int     m_relock;
  logic   m_lk1, m_lk2;

  function automatic void model_reset();
    m_ph     = P_PLL;
    m_now    = 0;
    m_tin    = 2;   // first edge the sequencer may act on is edge 3
    m_relock = 0;
    m_lk1    = 1'b0;
    m_lk2    = 1'b0;
  endfunction

  function automatic void enter(input phase_t p);
    m_ph  = p;
    m_tin = m_now;
  endfunction

  function automatic void model_step(input logic lk_in, input logic sw_in);
    logic lk_s;
    int   e;
    m_now++;
    lk_s  = m_lk2;        // pll_locked as applied two edges ago
    m_lk2 = m_lk1;
    m_lk1 = lk_in;
    if (m_now >= 3) begin
      e = m_now - m_tin;
      case (m_ph)
        P_PLL:  if (e == PLL_C) enter(P_WAIT);
        P_WAIT: if (lk_s) enter(P_STAB);
                else if (e == TO_C) enter(P_PLL);
        P_STAB: if (!lk_s) enter(P_WAIT);
                else if (e == STB_C) enter(P_REL);
        default: begin
          if (!lk_s) begin
            enter(P_PLL);
            if (m_relock < 255) m_relock++;
          end else if (m_ph == P_REL && e == (N_RST - 1) * STG_C + 1) begin
            enter(P_RUN);
          end else if (m_ph == P_RUN && sw_in) begin
            enter(P_STAB);
          end
        end
      endcase
    end
  endfunction

  function automatic exp_t model_out();
    exp_t x;
    int   k;
    x.pll  = (m_ph == P_PLL);
    x.done = (m_ph == P_RUN);
    x.rc   = 8'(m_relock);
    x.sys  = '0;
    if (m_ph == P_RUN) begin
      x.sys = '1;
    end else if (m_ph == P_REL) begin
      k = (m_now - m_tin) / STG_C + 1;
      if (k > N_RST) k = N_RST;
      for (int i = 0; i < k; i++) x.sys[i] = 1'b1;
    end
    return x;
  endfunction

  function automatic void check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // monitor
  always begin
    exp_t x;
    @(negedge clk or ev_async);
    if (sb_q.size() != 0) begin
      x = sb_q.pop_front();
      check("pll_rst",      int'(pll_rst),      int'(x.pll));
      check("sys_rst_n",    int'(sys_rst_n),    int'(x.sys));
      check("rst_done",     int'(rst_done),     int'(x.done));
      check("relock_count", int'(relock_count), int'(x.rc));
    end
  end

  task automatic tick(input logic lk, input logic sw);
    pll_locked   = lk;
    sw_reset_req = sw;
    @(posedge clk);
    #1;
    model_step(lk, sw);
    sb_q.push_back(model_out());
  endtask

  // Asserts rst_n between clock edges so the queued check sees the effect
  // of the asynchronous clear before any edge occurs.
  task automatic do_reset(input int ncyc);
    @(negedge clk);
    #2;
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;
    model_reset();
    sb_q.push_back(model_out());
    #1;
    -> ev_async;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      sb_q.push_back(model_out());
    end
    rst_n = 1'b1;
  endtask

  task automatic run_until(input phase_t target, input logic lk);
    for (int k = 0; k < 500 && m_ph != target; k++) tick(lk, 1'b0);
  endtask

  initial begin
    logic lk_r;
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;
    model_reset();

    // power-up, lock arrives at cycle 20
    do_reset(3);
    for (int k = 0; k < 19; k++) tick(1'b0, 1'b0);
    for (int k = 0; k < 40; k++) tick(1'b1, 1'b0);

    // software request in RUN, then ride through the restart
    tick(1'b1, 1'b1);
    for (int k = 0; k < 30; k++) tick(1'b1, 1'b0);

    // lose lock, then pulse the request while waiting for lock (ignored)
    tick(1'b0, 1'b0);
    run_until(P_WAIT, 1'b0);
    tick(1'b0, 1'b1);
    // lock never arrives: repeated PLL reset pulses
    for (int k = 0; k < 150; k++) tick(1'b0, 1'b0);

    // lock glitch partway through STABLE, then a clean relock
    run_until(P_STAB, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int k = 0; k < 40; k++) tick(1'b1, 1'b0);

    // lock loss and software request seen on the same edge
    run_until(P_RUN, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b0);

    // board reset in the middle of RELEASE
    run_until(P_REL, 1'b1);
    tick(1'b1, 1'b0);
    do_reset(2);
    for (int k = 0; k < 30; k++) tick(1'b1, 1'b0);

    // 300 lock losses in RELEASE or RUN: counter must saturate
    for (int l = 0; l < 300; l++) begin
      run_until(($urandom_range(0, 1) == 0) ? P_REL : P_RUN, 1'b1);
      for (int k = $urandom_range(1, 2); k > 0; k--) tick(1'b0, 1'b0);
    end
    for (int k = 0; k < 30; k++) tick(1'b1, 1'b0);

    // randomized lock activity and software requests
    do_reset(2);
    lk_r = 1'b1;
    for (int k = 0; k < 2500; k++) begin
      if (lk_r && $urandom_range(0, 99) < 2)       lk_r = 1'b0;
      else if (!lk_r && $urandom_range(0, 99) < 30) lk_r = 1'b1;
      tick(lk_r, ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
